// File: rtl/chroni_vram_arbiter_if.sv
// Bundle of signals between the VRAM arbiter, its two requesters and the VRAM.
// master is the environment side (requesters + VRAM); slave is the arbiter.
interface chroni_vram_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
);
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_valid;
   logic [DATA_W-1:0] vid_data;
   logic              vid_miss;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  vid_valid, vid_data, vid_miss, cpu_ack, cpu_rdata,
      input  mem_addr, mem_we, mem_wdata
   );

   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output vid_valid, vid_data, vid_miss, cpu_ack, cpu_rdata,
      output mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/chroni_vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has priority, CPU gets req/ack access
// with a starvation counter that forces a CPU slot during long video bursts.
//
// state      | meaning
// ST_IDLE    | no CPU access in flight; a CPU request may be granted
// ST_GRANTED | CPU access issued to VRAM this cycle
// ST_ACKWAIT | CPU read data returning; ack issued at the next edge
module chroni_vram_arbiter #(
   parameter int ADDR_W       = 11,
   parameter int DATA_W       = 8,
   parameter int STARVE_LIMIT = 32,
   parameter int CNT_W        = 6
) (
   input logic                  vga_clk,
   input logic                  reset_n,
   chroni_vram_arbiter_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_GRANTED, ST_ACKWAIT} cpu_state_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_t;

   cpu_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   tag_t              tag1_q, tag1_d;
   logic              vid_miss_q, vid_miss_d;
   tag_t              tag2_q;
   logic              we2_q;
   logic              vid_valid_q;
   logic [DATA_W-1:0] vid_data_q;
   logic              cpu_ack_q;
   logic [DATA_W-1:0] cpu_rdata_q;

   logic cpu_idle;
   logic starved;
   logic cpu_grant;

   assign cpu_idle = (state_q == ST_IDLE);
   assign starved  = (cnt_q == CNT_W'(STARVE_LIMIT));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      tag1_d      = TAG_NONE;
      vid_miss_d  = 1'b0;
      cpu_grant   = 1'b0;

      if (cpu_idle && bus.cpu_req && starved) begin
         cpu_grant  = 1'b1;
         vid_miss_d = bus.vid_req;
      end else if (bus.vid_req) begin
         tag1_d     = TAG_VID;
         mem_addr_d = bus.vid_addr;
         // cannot overflow: reaching STARVE_LIMIT forces the grant above
         if (cpu_idle && bus.cpu_req) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (cpu_idle && bus.cpu_req) begin
         cpu_grant = 1'b1;
      end

      if (cpu_grant) begin
         tag1_d      = TAG_CPU;
         mem_addr_d  = bus.cpu_addr;
         mem_we_d    = bus.cpu_we;
         mem_wdata_d = bus.cpu_wdata;
         cnt_d       = '0;
      end

      if (!bus.cpu_req) begin
         cnt_d = '0;
      end

      case (state_q)
         ST_IDLE:    if (cpu_grant) state_d = ST_GRANTED;
         ST_GRANTED: state_d = ST_ACKWAIT;
         ST_ACKWAIT: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         tag1_q      <= TAG_NONE;
         vid_miss_q  <= 1'b0;
         tag2_q      <= TAG_NONE;
         we2_q       <= 1'b0;
         vid_valid_q <= 1'b0;
         vid_data_q  <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         tag1_q      <= tag1_d;
         vid_miss_q  <= vid_miss_d;
         // tag2 tracks the access whose read data is on mem_rdata this cycle
         tag2_q      <= tag1_q;
         we2_q       <= mem_we_q;
         vid_valid_q <= (tag2_q == TAG_VID);
         cpu_ack_q   <= (tag2_q == TAG_CPU);
         if (tag2_q == TAG_VID) begin
            vid_data_q <= bus.mem_rdata;
         end
         if ((tag2_q == TAG_CPU) && !we2_q) begin
            cpu_rdata_q <= bus.mem_rdata;
         end
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.vid_valid = vid_valid_q;
   assign bus.vid_data  = vid_data_q;
   assign bus.vid_miss  = vid_miss_q;
   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_chroni_vram_arbiter.sv
// Bench for chroni_vram_arbiter: VRAM model, per-cycle reference model of the
// arbitration rules, and directed scenarios with literal expectations.
module tb_chroni_vram_arbiter;
   localparam int AW  = 11;
   localparam int DW  = 8;
   localparam int LIM = 32;

   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 vga_clk = ~vga_clk;

   chroni_vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   chroni_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM), .CNT_W(6)) dut (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // VRAM: synchronous 1-cycle read, preloaded with addr[7:0]
   logic [DW-1:0] vram [0:2047];
   bit vram_loaded = 1'b0;
   always @(posedge vga_clk) begin
      if (!vram_loaded) begin
         for (int i = 0; i < 2048; i++) vram[i] <= 8'(i);
         vram_loaded <= 1'b1;
      end else begin
         if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
         bus.mem_rdata <= vram[bus.mem_addr];
      end
   end

   // Reference model: expected outputs after each edge, from the arbitration rules
   logic [DW-1:0] smem [0:2047];
   bit            m_loaded = 1'b0;
   logic [AW-1:0] e_mem_addr;
   logic          e_mem_we, e_vid_miss, e_vid_valid, e_cpu_ack;
   logic [DW-1:0] e_mem_wdata, e_vid_data, e_cpu_rdata;
   int            p1_kind, p2_kind;   // 0 none, 1 video, 2 cpu
   logic          p1_we, p2_we;
   logic [DW-1:0] p1_data, p2_data;
   int            cpu_block, starve, kind;
   bit            m_idle, m_forced;

   always @(posedge vga_clk) begin
      if (!m_loaded) begin
         for (int i = 0; i < 2048; i++) smem[i] = 8'(i);
         m_loaded = 1'b1;
      end
      if (!reset_n) begin
         e_mem_addr = '0; e_mem_we = 1'b0; e_mem_wdata = '0; e_vid_miss = 1'b0;
         e_vid_valid = 1'b0; e_vid_data = '0; e_cpu_ack = 1'b0; e_cpu_rdata = '0;
         p1_kind = 0; p2_kind = 0; p1_we = 1'b0; p2_we = 1'b0;
         p1_data = '0; p2_data = '0; cpu_block = 0; starve = 0;
      end else begin
         e_vid_valid = (p2_kind == 1);
         if (p2_kind == 1) e_vid_data = p2_data;
         e_cpu_ack = (p2_kind == 2);
         if (p2_kind == 2 && !p2_we) e_cpu_rdata = p2_data;
         p2_kind = p1_kind; p2_we = p1_we; p2_data = p1_data;

         m_idle   = (cpu_block == 0);
         m_forced = m_idle && bus.cpu_req && (starve == LIM);
         kind = 0; e_mem_we = 1'b0; e_vid_miss = 1'b0; p1_we = 1'b0;
         if (m_forced || (!bus.vid_req && m_idle && bus.cpu_req)) kind = 2;
         else if (bus.vid_req) kind = 1;

         if (kind == 2) begin
            e_vid_miss  = m_forced && bus.vid_req;
            e_mem_addr  = bus.cpu_addr;
            e_mem_we    = bus.cpu_we;
            e_mem_wdata = bus.cpu_wdata;
            if (bus.cpu_we) smem[bus.cpu_addr] = bus.cpu_wdata;
            p1_data   = smem[bus.cpu_addr];
            p1_we     = bus.cpu_we;
            cpu_block = 2;
            starve    = 0;
         end else begin
            if (cpu_block > 0) cpu_block--;
            if (kind == 1) begin
               e_mem_addr = bus.vid_addr;
               p1_data    = smem[bus.vid_addr];
               if (m_idle && bus.cpu_req) starve = (starve < LIM) ? starve + 1 : LIM;
            end
         end
         if (!bus.cpu_req) starve = 0;
         p1_kind = kind;
      end
   end

   always @(negedge vga_clk) begin
      if (chk_en) begin
         chk("mem_addr", 32'(bus.mem_addr), 32'(e_mem_addr));
         chk("mem_we", 32'(bus.mem_we), 32'(e_mem_we));
         if (e_mem_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_mem_wdata));
         chk("vid_miss", 32'(bus.vid_miss), 32'(e_vid_miss));
         chk("vid_valid", 32'(bus.vid_valid), 32'(e_vid_valid));
         if (e_vid_valid) chk("vid_data", 32'(bus.vid_data), 32'(e_vid_data));
         chk("cpu_ack", 32'(bus.cpu_ack), 32'(e_cpu_ack));
         chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_cpu_rdata));
      end
   end

   // Waits for cpu_ack, counting cycles from the first sampling edge
   task automatic wait_ack(input int maxc, output int cyc, output int we_cnt,
                           output logic [AW-1:0] we_addr);
      cyc = 0; we_cnt = 0; we_addr = '0;
      do begin
         @(negedge vga_clk);
         cyc++;
         if (bus.mem_we) begin we_cnt++; we_addr = bus.mem_addr; end
      end while (!bus.cpu_ack && cyc < maxc);
      chk("ack_seen", 32'(bus.cpu_ack), 32'd1);
   endtask

   int            cyc, we_cnt, bad, nval, first_v, miss_cnt, gnt_cyc, ack_cyc, ack_cnt;
   logic [AW-1:0] we_addr, addr_after;
   logic [DW-1:0] rd_after;
   int            ack_at [0:2];

   initial begin
      bus.vid_req = 1'b0; bus.vid_addr = '0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      repeat (2) @(negedge vga_clk);
      chk_en = 1'b1;
      repeat (2) @(negedge vga_clk);
      reset_n = 1'b1;

      // quiet after reset
      bad = 0;
      repeat (10) begin
         @(negedge vga_clk);
         if (bus.mem_we || bus.vid_valid || bus.cpu_ack || bus.vid_miss) bad++;
      end
      chk("idle_quiet", 32'(bad), 32'd0);

      // continuous video burst 1024..1031
      nval = 0; first_v = 0; bad = 0;
      for (int k = 0; k < 11; k++) begin
         bus.vid_req  = (k < 8);
         bus.vid_addr = AW'(1024 + k);
         @(negedge vga_clk);
         if (bus.vid_valid) begin
            if (nval == 0) first_v = k + 1;
            if (bus.vid_data !== 8'(nval)) bad++;
            nval++;
         end
      end
      bus.vid_req = 1'b0;
      chk("vid_count", 32'(nval), 32'd8);
      chk("vid_first_cycle", 32'(first_v), 32'd3);
      chk("vid_order", 32'(bad), 32'd0);

      // CPU write then read back
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 11'h010; bus.cpu_wdata = 8'h5A;
      wait_ack(10, cyc, we_cnt, we_addr);
      bus.cpu_req = 1'b0;
      chk("wr_ack_cycle", 32'(cyc), 32'd3);
      chk("wr_we_pulses", 32'(we_cnt), 32'd1);
      chk("wr_we_addr", 32'(we_addr), 32'h010);
      bus.cpu_we = 1'b0;
      @(negedge vga_clk);
      bus.cpu_req = 1'b1;
      wait_ack(10, cyc, we_cnt, we_addr);
      bus.cpu_req = 1'b0;
      chk("rd_ack_cycle", 32'(cyc), 32'd3);
      chk("rd_data", 32'(bus.cpu_rdata), 32'h5A);
      repeat (3) @(negedge vga_clk);

      // starvation: video every cycle, CPU read of 0x020
      bus.cpu_we = 1'b0; bus.cpu_addr = 11'h020; bus.cpu_req = 1'b1;
      miss_cnt = 0; gnt_cyc = 0; ack_cyc = 0; addr_after = '0; rd_after = '0;
      for (int i = 0; i < 40; i++) begin
         bus.vid_req = 1'b1; bus.vid_addr = AW'(11'h100 + i);
         @(negedge vga_clk);
         if (bus.vid_miss) miss_cnt++;
         if (gnt_cyc == 0 && bus.mem_addr == 11'h020) gnt_cyc = i + 1;
         if (gnt_cyc != 0 && i + 1 == gnt_cyc + 1) addr_after = bus.mem_addr;
         if (bus.cpu_ack && ack_cyc == 0) begin
            ack_cyc = i + 1; rd_after = bus.cpu_rdata; bus.cpu_req = 1'b0;
         end
      end
      bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
      chk("starve_grant_cycle", 32'(gnt_cyc), 32'd33);
      chk("starve_ack_latency", 32'(ack_cyc - gnt_cyc), 32'd2);
      chk("starve_miss_count", 32'(miss_cnt), 32'd1);
      chk("starve_video_resume", 32'(addr_after), 32'h121);
      chk("starve_rdata", 32'(rd_after), 32'h20);
      repeat (3) @(negedge vga_clk);

      // CPU request held across acks
      bus.cpu_we = 1'b0; bus.cpu_addr = 11'h005; bus.cpu_req = 1'b1;
      ack_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge vga_clk);
         if (bus.cpu_ack) begin
            if (ack_cnt < 3) ack_at[ack_cnt] = i + 1;
            ack_cnt++;
         end
      end
      bus.cpu_req = 1'b0;
      chk("hold_ack_count", 32'(ack_cnt), 32'd3);
      if (ack_cnt == 3) begin
         chk("hold_ack0", 32'(ack_at[0]), 32'd3);
         chk("hold_ack1", 32'(ack_at[1]), 32'd6);
         chk("hold_ack2", 32'(ack_at[2]), 32'd9);
      end
      repeat (4) @(negedge vga_clk);

      // reset one cycle after a CPU read grant
      bus.cpu_addr = 11'h007; bus.cpu_req = 1'b1;
      ack_cnt = 0;
      @(negedge vga_clk);
      reset_n = 1'b0;
      repeat (3) begin
         @(negedge vga_clk);
         if (bus.cpu_ack) ack_cnt++;
      end
      chk("reset_no_ack", 32'(ack_cnt), 32'd0);
      reset_n = 1'b1;
      wait_ack(10, cyc, we_cnt, we_addr);
      bus.cpu_req = 1'b0;
      chk("post_reset_ack_cycle", 32'(cyc), 32'd3);
      chk("post_reset_rdata", 32'(bus.cpu_rdata), 32'h07);
      repeat (4) @(negedge vga_clk);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/chroni_vram_arbiter.md
Name: chroni_vram_arbiter

Overview:
- Shares the single-port text/font VRAM (11-bit address, 8-bit data, synchronous 1-cycle read) between two requesters.
- Requester 1 is the chroni video fetch path: fixed latency, highest priority.
- Requester 2 is the CPU bus port: req/ack handshake.
- Sits between chroni's fetch address output and the VRAM block. An anti-starvation counter guarantees CPU progress while the display window is active.

Parameters:
ADDR_W, 11, VRAM address width
DATA_W, 8, VRAM data width
STARVE_LIMIT, 32, consecutive cycles a pending CPU request may be denied before it is forced through
CNT_W, 6, starvation counter width; must hold STARVE_LIMIT

Ports:
vga_clk  in  1  clock; all logic on rising edge
reset_n  in  1  reset, synchronous, active-low
vid_req  in  1  video fetch request this cycle
vid_addr  in  ADDR_W  video fetch address
vid_valid  out  1  vid_data valid (pulse)
vid_data  out  DATA_W  video read data
vid_miss  out  1  pulse: a video request was dropped in favour of a forced CPU access
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
cpu_addr  in  ADDR_W  CPU address; stable while cpu_req is high
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  pulse: access complete; cpu_rdata valid on reads
cpu_rdata  out  DATA_W  CPU read data
mem_addr  out  ADDR_W  registered VRAM address
mem_we  out  1  registered VRAM write enable
mem_wdata  out  DATA_W  registered VRAM write data
mem_rdata  in  DATA_W  VRAM read data; valid one cycle after mem_addr

Behaviour:
- Reset (reset_n=0 at an edge):
  - All outputs 0; state IDLE; starvation counter 0; in-flight pipeline tags cleared.
  - No ack or valid is issued for an access in flight at reset.
  - A CPU request still held after reset is served as new.
- Grant decision at edge E0 (from sampled inputs), registered into mem_* plus a 2-bit tag (NONE/VID/CPU) for E1:
  - CPU forced: state IDLE, cpu_req=1 and counter==STARVE_LIMIT → grant CPU. If vid_req=1 as well, pulse vid_miss at E1 and give no vid_valid for that request.
  - Video: else if vid_req=1 → grant video (mem_addr=vid_addr, mem_we=0).
  - CPU normal: else if state IDLE and cpu_req=1 → grant CPU (mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata).
  - None: else mem_we=0, mem_addr holds its value, tag NONE.
- mem_we is high for exactly one cycle per CPU write; video never writes.
- Return path at E2 (tag delayed one stage):
  - VID → vid_valid=1, vid_data=mem_rdata.
  - CPU → cpu_ack=1; cpu_rdata=mem_rdata for reads; cpu_rdata holds its value for writes.
  - Latency from request sampling to vid_valid or cpu_ack is exactly 2 cycles.
- CPU FSM:
  - IDLE → GRANTED on CPU grant; GRANTED → ACKWAIT at E1; ACKWAIT → IDLE at E2 (the ack edge).
  - cpu_req is ignored outside IDLE, so a request still high in the ack cycle is not double-served. The next CPU grant is possible at the edge after cpu_ack.
  - Back-to-back CPU accesses therefore occur at most every 3 cycles.
- Starvation counter:
  - Increments when state IDLE, cpu_req=1 and the CPU is denied; saturates at STARVE_LIMIT.
  - Clears on any CPU grant and when cpu_req=0.
- vid_req may be high every cycle; each accepted request yields exactly one vid_valid, in order.
- vid_valid and cpu_ack are never high in the same cycle; each access has a single tag.
- Address wrap is not the arbiter's concern: addresses pass through unmodified at full width.

Test Plan:
- Reset release with no requests → all outputs 0 for 10 cycles; mem_we never high.
- vid_req continuous for addr 1024..1031, VRAM preloaded with addr[7:0] → vid_valid on 8 consecutive cycles starting 2 cycles after the first request, data 0x00..0x07 in order.
- CPU write 0x5A to 0x010, vid_req=0 → mem_we high for one cycle with mem_addr=0x010; cpu_ack 2 cycles after req. Then CPU read of 0x010 → cpu_rdata=0x5A with cpu_ack.
- vid_req held high and cpu_req raised → CPU denied for exactly 32 cycles; on the 33rd, forced grant; vid_miss pulses once; cpu_ack 2 cycles after grant; video resumes the next cycle.
- cpu_req held high across its ack → second grant no earlier than the edge after cpu_ack; exactly one cpu_ack per grant.
- reset_n asserted one cycle after a CPU read grant → no cpu_ack. After reset release with cpu_req still high → fresh grant and cpu_ack 2 cycles later.
